// File: rtl/bram_arb_pkg.sv
// Shared types for the two-requester byte-enable BRAM arbiter.
package bram_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // With two requesters the "other" requester is simply the inverted index.
  function automatic req_idx_t other_req(req_idx_t r);
    return ~r;
  endfunction

endpackage

// File: rtl/bram_be_arbiter_if.sv
// Requester + RAM bundle for bram_be_arbiter.
//
// Handshake: a request transfers in the cycle REQ_VALID[r] and REQ_READY[r]
// are both high; REQ_VALID must not depend on REQ_READY. A read response
// transfers in the cycle RESP_VALID[r] and RESP_READY[r] are both high;
// RESP_DO[r] is held unchanged while RESP_VALID[r] is high and not accepted.
// ARB_LAST reports the arbiter's last-grant state for observation.
interface bram_be_arbiter_if
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);

  logic [NUM_REQ-1:0]                 REQ_VALID;
  logic [NUM_REQ-1:0]                 REQ_READY;
  logic [NUM_REQ-1:0]                 REQ_WE;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] REQ_ADDR;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] REQ_DI;
  logic [NUM_REQ-1:0][BE_WIDTH-1:0]   REQ_BE;
  logic [NUM_REQ-1:0]                 RESP_VALID;
  logic [NUM_REQ-1:0]                 RESP_READY;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] RESP_DO;
  logic [DATA_WIDTH-1:0]              RAM_DI;
  logic [ADDR_WIDTH-1:0]              RAM_ADDR;
  logic                               RAM_WE;
  logic                               RAM_RE;
  logic [BE_WIDTH-1:0]                RAM_BE;
  logic [DATA_WIDTH-1:0]              RAM_DO;
  req_idx_t                           ARB_LAST;

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_DI, REQ_BE, RESP_READY, RAM_DO,
    output REQ_READY, RESP_VALID, RESP_DO, RAM_DI, RAM_ADDR, RAM_WE, RAM_RE,
           RAM_BE, ARB_LAST
  );

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_DI, REQ_BE, RESP_READY, RAM_DO,
    input  REQ_READY, RESP_VALID, RESP_DO, RAM_DI, RAM_ADDR, RAM_WE, RAM_RE,
           RAM_BE, ARB_LAST
  );

endinterface

// File: rtl/bram_arb_rr.sv
// Two-way tie-break with last-grant state.
// Define BRAM_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
module bram_arb_rr
  import bram_arb_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] elig_i,
  output logic [NUM_REQ-1:0] grant_o,
  output req_idx_t           last_o
);

  req_idx_t last_q, last_d;

  // Single eligible requester always wins; a tie goes by the tie-break rule.
  always_comb begin
    grant_o = '0;
    case (elig_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11: begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
        grant_o = 2'b01;
`else
        grant_o = 2'b01 << other_req(last_q);
`endif
      end
      default: grant_o = '0;
    endcase
  end

  // Remember who was granted most recently.
  always_comb begin
    last_d = last_q;
    if (|grant_o) last_d = req_idx_t'(grant_o[1]);
  end

  // Last-grant register; reset favours requester 0 on the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= req_idx_t'(1);
    else       last_q <= last_d;
  end

  assign last_o = last_q;

endmodule

// File: rtl/bram_be_arbiter.sv
// Two-requester arbiter in front of a single-port byte-enable block RAM.
// Reads return through a one-entry response register per requester, two
// cycles after the grant. Optional macro: BRAM_ARB_FIXED_PRIO_EN (requester 0
// wins ties instead of round-robin).
module bram_be_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
)(
  input  logic              CLK,
  input  logic              RST,
  bram_be_arbiter_if.slave  bus_io
);

  logic [NUM_REQ-1:0]                 elig;
  logic [NUM_REQ-1:0]                 grant;
  logic [NUM_REQ-1:0]                 rd_pend_q, rd_pend_d;
  logic [NUM_REQ-1:0]                 resp_valid_q, resp_valid_d;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  req_idx_t                           win;
  op_e                                win_op;
  logic [ADDR_WIDTH-1:0]              win_addr;
  logic [DATA_WIDTH-1:0]              win_di;
  logic [BE_WIDTH-1:0]                win_be;
  logic                               do_wr;
  logic                               do_rd;
  req_idx_t                           last_grant;

  // Writes are always eligible; a read needs a free response slot by the
  // time its data arrives (nothing in flight, register empty or draining).
  always_comb begin
    elig = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      elig[r] = !RST && bus_io.REQ_VALID[r] &&
                (bus_io.REQ_WE[r] ||
                 (!rd_pend_q[r] && (!resp_valid_q[r] || bus_io.RESP_READY[r])));
    end
  end

  bram_arb_rr u_rr (
    .clk_i   (CLK),
    .rst_i   (RST),
    .elig_i  (elig),
    .grant_o (grant),
    .last_o  (last_grant)
  );

  // Select the winner's operation and payload.
  always_comb begin
    win      = req_idx_t'(grant[1]);
    win_op   = bus_io.REQ_WE[win] ? OP_WRITE : OP_READ;
    win_addr = bus_io.REQ_ADDR[win];
    win_di   = bus_io.REQ_DI[win];
    win_be   = bus_io.REQ_BE[win];
    do_wr    = (|grant) && (win_op == OP_WRITE);
    do_rd    = (|grant) && (win_op == OP_READ);
  end

  // Drive the RAM and requester-facing outputs.
  always_comb begin
    bus_io.REQ_READY  = grant;
    bus_io.RAM_WE     = do_wr;
    bus_io.RAM_RE     = do_rd;
    bus_io.RAM_ADDR   = win_addr;
    bus_io.RAM_DI     = win_di;
    bus_io.RAM_BE     = do_wr ? win_be : '0;
    bus_io.RESP_VALID = resp_valid_q;
    bus_io.RESP_DO    = resp_data_q;
    bus_io.ARB_LAST   = last_grant;
  end

  // Track reads in flight and capture RAM_DO the cycle after the grant;
  // an accepted response clears valid but keeps its data.
  always_comb begin
    rd_pend_d    = '0;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    for (int r = 0; r < NUM_REQ; r++) begin
      rd_pend_d[r] = grant[r] && !bus_io.REQ_WE[r];
      if (rd_pend_q[r]) begin
        resp_valid_d[r] = 1'b1;
        resp_data_d[r]  = bus_io.RAM_DO;
      end else if (bus_io.RESP_READY[r]) begin
        resp_valid_d[r] = 1'b0;
      end
    end
  end

  // Response and in-flight state; reset drops any read in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_pend_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      rd_pend_q    <= rd_pend_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_bram_be_arbiter.sv
// Bench for bram_be_arbiter: behavioural BRAM, transaction-level reference
// model and directed plus random stimulus.
module tb_bram_be_arbiter;
  import bram_arb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_be_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

  bram_be_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
    .CLK    (clk),
    .RST    (rst),
    .bus_io (bus)
  );

  // ---------------- block RAM ----------------
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.RAM_WE)
      for (int b = 0; b < BW; b++)
        if (bus.RAM_BE[b]) ram_mem[bus.RAM_ADDR][8*b +: 8] <= bus.RAM_DI[8*b +: 8];
    if (bus.RAM_RE) bus.RAM_DO <= ram_mem[bus.RAM_ADDR];
  end

  // ---------------- drive variables ----------------
  logic                 drv_rst;
  logic [1:0]           drv_valid, drv_we, drv_rr;
  logic [1:0][AW-1:0]   drv_addr;
  logic [1:0][DW-1:0]   drv_di;
  logic [1:0][BW-1:0]   drv_be;

  // ---------------- scoreboard / model ----------------
  logic [DW-1:0] gold [0:(1<<AW)-1];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            due_q0[$];
  int            due_q1[$];
  int            cyc;
  logic          m_last;
  int            n_checks;
  int            n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit resp_due(int r);
    if (r == 0) return (due_q0.size() > 0) && (due_q0[0] <= cyc);
    return (due_q1.size() > 0) && (due_q1[0] <= cyc);
  endfunction

  function automatic bit rd_inflight(int r);
    if (r == 0) return (due_q0.size() > 0) && (due_q0[due_q0.size()-1] > cyc);
    return (due_q1.size() > 0) && (due_q1[due_q1.size()-1] > cyc);
  endfunction

  // One clock cycle: apply inputs, compare against the model, advance model.
  task automatic tick();
    logic [1:0]    el, eg;
    int            w;
    logic [DW-1:0] merged;
    @(negedge clk);
    rst            = drv_rst;
    bus.REQ_VALID  = drv_valid;
    bus.REQ_WE     = drv_we;
    bus.REQ_ADDR   = drv_addr;
    bus.REQ_DI     = drv_di;
    bus.REQ_BE     = drv_be;
    bus.RESP_READY = drv_rr;
    #1;
    if (drv_rst) begin
      check("rst_req_ready",  bus.REQ_READY,  0);
      check("rst_resp_valid", bus.RESP_VALID, 0);
      check("rst_ram_we",     bus.RAM_WE,     0);
      check("rst_ram_re",     bus.RAM_RE,     0);
      check("rst_ram_be",     bus.RAM_BE,     0);
      check("rst_resp_do",    bus.RESP_DO,    0);
      check("rst_last",       bus.ARB_LAST,   1);
      exp_q0.delete(); exp_q1.delete(); due_q0.delete(); due_q1.delete();
      m_last = 1'b1;
    end else begin
      for (int r = 0; r < 2; r++)
        el[r] = drv_valid[r] && (drv_we[r] ||
                (!rd_inflight(r) && (!resp_due(r) || drv_rr[r])));
      if (el == 2'b11) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
        eg = 2'b01;
`else
        eg = m_last ? 2'b01 : 2'b10;
`endif
      end else begin
        eg = el;
      end
      w = eg[1] ? 1 : 0;
      check("req_ready",  bus.REQ_READY, eg);
      check("ram_we",     bus.RAM_WE, (eg != 0) && drv_we[w]);
      check("ram_re",     bus.RAM_RE, (eg != 0) && !drv_we[w]);
      check("we_re_excl", bus.RAM_WE & bus.RAM_RE, 0);
      check("ram_be",     bus.RAM_BE, ((eg != 0) && drv_we[w]) ? drv_be[w] : '0);
      if (eg != 0) check("ram_addr", bus.RAM_ADDR, drv_addr[w]);
      if ((eg != 0) && drv_we[w]) check("ram_di", bus.RAM_DI, drv_di[w]);
      check("resp_valid", bus.RESP_VALID, {resp_due(1), resp_due(0)});
      if (resp_due(0)) check("resp_do0", bus.RESP_DO[0], exp_q0[0]);
      if (resp_due(1)) check("resp_do1", bus.RESP_DO[1], exp_q1[0]);
      // state after the coming rising edge
      if (resp_due(0) && drv_rr[0]) begin void'(exp_q0.pop_front()); void'(due_q0.pop_front()); end
      if (resp_due(1) && drv_rr[1]) begin void'(exp_q1.pop_front()); void'(due_q1.pop_front()); end
      if (eg != 0) begin
        m_last = w[0];
        if (drv_we[w]) begin
          merged = gold[drv_addr[w]];
          for (int b = 0; b < BW; b++)
            if (drv_be[w][b]) merged[8*b +: 8] = drv_di[w][8*b +: 8];
          gold[drv_addr[w]] = merged;
        end else if (w == 0) begin
          exp_q0.push_back(gold[drv_addr[0]]); due_q0.push_back(cyc + 2);
        end else begin
          exp_q1.push_back(gold[drv_addr[1]]); due_q1.push_back(cyc + 2);
        end
      end
    end
    cyc++;
  endtask

  // ---------------- driver helpers ----------------
  task automatic clear_reqs();
    drv_valid = '0; drv_we = '0; drv_addr = '0; drv_di = '0; drv_be = '0;
  endtask

  task automatic set_req(input int r, input bit we, input int addr,
                         input logic [DW-1:0] di, input logic [BW-1:0] be);
    drv_valid[r] = 1'b1;
    drv_we[r]    = we;
    drv_addr[r]  = AW'(addr);
    drv_di[r]    = di;
    drv_be[r]    = be;
  endtask

  task automatic idle(input int n);
    clear_reqs();
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first;
    n_checks = 0; n_fail = 0; cyc = 0; m_last = 1'b1;
    rst = 1'b1;
    clear_reqs(); drv_rr = 2'b11; drv_rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    drv_rst = 1'b0;
    idle(2);

    // full write then read-back
    set_req(0, 1'b1, 'h10, 32'hAABBCCDD, 4'hF); tick();
    clear_reqs(); set_req(0, 1'b0, 'h10, '0, '0); tick();
    idle(2);
    check("dir_full_valid", bus.RESP_VALID[0], 1);
    check("dir_full_data",  bus.RESP_DO[0], 32'hAABBCCDD);

    // partial write then read-back
    set_req(0, 1'b1, 'h10, 32'h11112222, 4'h3); tick();
    clear_reqs(); set_req(0, 1'b0, 'h10, '0, '0); tick();
    idle(2);
    check("dir_part_data", bus.RESP_DO[0], 32'hAABB2222);
    idle(2);

    // reset in the cycle after a read grant
    drv_rr = 2'b00;
    set_req(0, 1'b0, 'h10, '0, '0); tick();
    clear_reqs(); drv_rst = 1'b1; tick();
    drv_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_drop_resp", bus.RESP_VALID, 0);
    end
    drv_rr = 2'b11;

    // both read continuously: strict alternation starting with requester 0
    set_req(0, 1'b0, 'h10, '0, '0);
    set_req(1, 1'b0, 'h10, '0, '0);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("alt_grant", bus.REQ_READY, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("alt_re",    bus.RAM_RE, 1);
    end
    idle(3);

    // held response blocks requester 0, requester 1 writes keep flowing
    set_req(0, 1'b0, 'h10, '0, '0); tick();
    drv_rr = 2'b10;
    set_req(1, 1'b1, 'h20, 32'h5A5A0001, 4'hF);
    for (int k = 0; k < 6; k++) begin
      drv_di[1] = DW'($urandom);
      tick();
      check("hold_grant", bus.REQ_READY, 2'b10);
      if (k >= 1) begin
        check("hold_valid", bus.RESP_VALID[0], 1);
        check("hold_data",  bus.RESP_DO[0], 32'hAABB2222);
      end
    end
    drv_rr = 2'b11; tick();
    idle(3);

    // prefill the random address window
    for (int a = 0; a < 32; a++) begin
      clear_reqs(); set_req(a % 2, 1'b1, a, DW'($urandom), 4'hF); tick();
    end

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      drv_rst = ($urandom_range(0, 199) == 0);
      for (int r = 0; r < 2; r++) begin
        drv_valid[r] = ($urandom_range(0, 3) != 0);
        drv_we[r]    = ($urandom_range(0, 2) == 0);
        drv_addr[r]  = AW'($urandom_range(0, 31));
        drv_di[r]    = DW'($urandom);
        drv_be[r]    = BW'($urandom_range(0, 15));
        drv_rr[r]    = ($urandom_range(0, 9) < 7);
      end
      tick();
    end
    drv_rst = 1'b0; drv_rr = 2'b11;
    idle(4);

    // continuous writes from both: tie-break behaviour
    first = m_last ? 0 : 1;
    set_req(0, 1'b1, 'h30, 32'h0000_0000, 4'hF);
    set_req(1, 1'b1, 'h31, 32'h1111_1111, 4'hF);
    for (int k = 0; k < 10; k++) begin
      tick();
`ifdef BRAM_ARB_FIXED_PRIO_EN
      check("tie_fixed", bus.REQ_READY, 2'b01);
`else
      check("tie_rr", bus.REQ_READY, 2'b01 << ((first + k) % 2));
`endif
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_be_arbiter.md
BRAM_BE_ARBITER -- requirements
Module: bram_be_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, RAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM word width; a multiple of 8.
REQ-003 SHALL have parameter BE_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-004 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port REQ_VALID  input  2  per-requester request valid (bit r = requester r).
REQ-007 SHALL have port REQ_READY  output  2  per-requester grant; a transfer occurs when VALID and READY are both high.
REQ-008 SHALL have port REQ_WE  input  2  1 = write request, 0 = read request.
REQ-009 SHALL have port REQ_ADDR  input  2xADDR_WIDTH  request word address.
REQ-010 SHALL have port REQ_DI  input  2xDATA_WIDTH  write data.
REQ-011 SHALL have port REQ_BE  input  2xBE_WIDTH  write byte enables.
REQ-012 SHALL have port RESP_VALID  output  2  read data valid.
REQ-013 SHALL have port RESP_READY  input  2  read response accepted.
REQ-014 SHALL have port RESP_DO  output  2xDATA_WIDTH  read data.
REQ-015 SHALL have ports RAM_DI/RAM_ADDR/RAM_WE/RAM_RE/RAM_BE  output and RAM_DO  input, widths per parameters; these drive the single-port byte-enable block RAM.

Function
REQ-016 SHALL issue at most one RAM operation per cycle and SHALL grant at most one REQ_READY bit per cycle.
REQ-017 SHALL drive RAM_WE = grant & REQ_WE and RAM_RE = grant & ~REQ_WE of the winner, combinationally; it SHALL never assert RAM_WE and RAM_RE together.
REQ-018 SHALL route the winner's ADDR, DI and BE to the RAM ports; RAM_BE SHALL be 0 when no write is granted.
REQ-019 Eligibility: requester r SHALL be eligible if REQ_VALID[r] and either (a) REQ_WE[r] = 1, or (b) no read is in flight for r and (RESP_VALID[r] = 0 or RESP_READY[r] = 1).
REQ-020 Arbitration SHALL be round-robin: if both are eligible, the requester not granted last wins; a single eligible requester always wins; an ineligible requester SHALL NOT block the other.
REQ-021 Read latency: a read granted in cycle N SHALL have RAM_DO sampled in N+1 into a one-entry response register, and RESP_VALID[r] SHALL be high from N+2 until the cycle RESP_READY[r] is high.
REQ-022 RESP_DO[r] SHALL hold stable while RESP_VALID[r] is high and not accepted.
REQ-023 Writes SHALL produce no response; the RAM is written on the edge ending the grant cycle.
REQ-024 A read of address A granted in the cycle after a write to A by either requester SHALL return the new data.
REQ-025 Each requester's reads SHALL complete in issue order; the maximum per-requester read rate is one per 2 cycles.

Reset
REQ-026 While RST is high: REQ_READY = 0, RESP_VALID = 0, RAM_WE = 0, RAM_RE = 0, RAM_BE = 0, and RESP_DO = 0.
REQ-027 Reset SHALL clear in-flight flags; a read in flight at reset SHALL produce no response.
REQ-028 Reset SHALL set last-grant to requester 1, so requester 0 wins the first tie.

Configuration
REQ-029 If BRAM_ARB_FIXED_PRIO_EN is defined, requester 0 SHALL win every tie; otherwise the round-robin of REQ-020 applies. Eligibility rules are unchanged in both cases.

Structure
REQ-030 The package bram_arb_pkg SHALL hold NUM_REQ = 2, the requester-index typedef and the op typedef (READ/WRITE).
REQ-031 The tie-break SHALL be a sub-module bram_arb_rr (2-way round-robin with last-grant state and fixed-priority option); the response registers and eligibility logic stay in the top module.

Verification
REQ-032 Write to requester 0 at addr 0x10, data 0xAABBCCDD, BE 0xF; then read at 0x10 -> RESP_DO[0] = 0xAABBCCDD two cycles after the read grant.
REQ-033 Partial write: BE 0x3, data 0x11112222 over 0xAABBCCDD at 0x10 -> read returns 0xAABB2222.
REQ-034 Both requesters read continuously with RESP_READY high -> grants alternate 0,1,0,1; RAM_RE is high every cycle; RAM_WE and RAM_RE are never both high.
REQ-035 Requester 0 read response is held (RESP_READY[0] = 0 for 5 cycles) while requester 0 has a further read pending -> no further grant to 0, RESP_DO[0] is stable, requester 1 writes are still granted every cycle.
REQ-036 RST asserted in the cycle after a read grant -> RESP_VALID stays 0 after release; the first tie is then won by requester 0.
REQ-037 With BRAM_ARB_FIXED_PRIO_EN defined, both requesters issue continuous writes -> requester 0 is granted every cycle and requester 1 never.
